// File: rtl/video2ram_if.sv
// Video input and line-buffer RAM write port bundle for video2ram.
// master drives the video stream and observes the RAM write side; slave is the capture block.
interface video2ram_if;
    logic [23:0] vid_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [14:0] wraddr;
    logic [23:0] wrdata;
    logic        wren;
    logic        starttrigger;
    logic        locked;

    modport master (
        output vid_in, hsync_in, vsync_in,
        input  wraddr, wrdata, wren, starttrigger, locked
    );

    modport slave (
        input  vid_in, hsync_in, vsync_in,
        output wraddr, wrdata, wren, starttrigger, locked
    );
endinterface

// File: rtl/video2ram.sv
// Captures the visible window of the incoming video stream into the line-buffer RAM.
// Optional macro VIDEO2RAM_TESTPATTERN_EN replaces pixel data with a position pattern.
module video2ram #(
    parameter int BUFFER_LINE_LENGTH = 640,
    parameter int RAM_NUMWORDS       = 23040,
    parameter int H_CAPTURE_START    = 100,
    parameter int V_CAPTURE_START    = 20,
    parameter int V_CAPTURE_LINES    = 480,
    parameter int TRIGGER_LINE       = 8
) (
    input  logic        clock,
    input  logic        reset,
    video2ram_if.slave  vif
);
    localparam logic [11:0] X_START   = 12'(H_CAPTURE_START);
    localparam logic [11:0] X_END     = 12'(H_CAPTURE_START + BUFFER_LINE_LENGTH);
    localparam logic [10:0] Y_START   = 11'(V_CAPTURE_START);
    localparam logic [10:0] Y_END     = 11'(V_CAPTURE_START + V_CAPTURE_LINES);
    localparam logic [10:0] Y_TRIG    = 11'(V_CAPTURE_START + TRIGGER_LINE);
    localparam logic [15:0] LINE_STEP = 16'(BUFFER_LINE_LENGTH);
    localparam logic [15:0] RAM_WORDS = 16'(RAM_NUMWORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_RUN} state_t;

    logic [23:0] r_vid;
    logic        r_hs, r_hs_d, r_vs, r_vs_d;
    logic [11:0] r_x;
    logic [10:0] r_y;
    logic [14:0] r_base;
    logic        r_trig_done;
    state_t      r_state;
    logic        r_seen_hs;
    logic        r_locked;
    logic        r_wren;
    logic [14:0] r_wraddr;
    logic [23:0] r_wrdata;
    logic        r_trig;

    logic        w_hs_edge, w_vs_edge, w_run, w_cap, w_trig, w_line_end;
    logic [11:0] w_x;
    logic [10:0] w_y;
    logic [14:0] w_addr;
    logic [15:0] w_base_inc;
    logic [23:0] w_pix;

    assign w_hs_edge = r_hs_d & ~r_hs;
    assign w_vs_edge = r_vs_d & ~r_vs;
    assign w_run     = (r_state == ST_RUN);

    // w_x/w_y are the position of the pixel currently held in r_vid; they become r_x/r_y next clock.
    assign w_x = w_hs_edge ? 12'd0 : ((r_x == 12'hFFF) ? r_x : r_x + 12'd1);
    assign w_y = w_vs_edge ? 11'd0
               : ((w_hs_edge && (r_y != 11'h7FF)) ? r_y + 11'd1 : r_y);

    assign w_cap = w_run && (w_x >= X_START) && (w_x < X_END)
                         && (w_y >= Y_START) && (w_y < Y_END);
    assign w_trig     = w_cap && (w_x == X_START) && (w_y == Y_TRIG) && !r_trig_done;
    assign w_addr     = r_base + {3'd0, w_x - X_START};
    assign w_base_inc = {1'b0, r_base} + LINE_STEP;
    // r_y still holds the line that this hsync edge terminates.
    assign w_line_end = w_hs_edge && w_run && (r_y >= Y_START) && (r_y < Y_END);

`ifdef VIDEO2RAM_TESTPATTERN_EN
    assign w_pix = {w_x[7:0] - X_START[7:0], w_y[7:0], 8'h80};
`else
    assign w_pix = r_vid;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vid       <= '0;
            r_hs        <= 1'b1;
            r_hs_d      <= 1'b1;
            r_vs        <= 1'b1;
            r_vs_d      <= 1'b1;
            r_x         <= '0;
            r_y         <= '0;
            r_base      <= '0;
            r_trig_done <= 1'b0;
            r_wren      <= 1'b0;
            r_wraddr    <= '0;
            r_wrdata    <= '0;
            r_trig      <= 1'b0;
        end else begin
            r_vid  <= vif.vid_in;
            r_hs   <= vif.hsync_in;
            r_hs_d <= r_hs;
            r_vs   <= vif.vsync_in;
            r_vs_d <= r_vs;
            r_x    <= w_x;
            r_y    <= w_y;

            if (w_vs_edge) begin
                r_base <= '0;
            end else if (w_line_end) begin
                r_base <= (w_base_inc >= RAM_WORDS) ? 15'd0 : w_base_inc[14:0];
            end

            if (w_vs_edge) begin
                r_trig_done <= 1'b0;
            end else if (w_trig) begin
                r_trig_done <= 1'b1;
            end

            r_wren <= w_cap;
            r_trig <= w_trig;
            if (w_cap) begin
                r_wraddr <= w_addr;
                r_wrdata <= w_pix;
            end
        end
    end

    // Lock needs two vsync edges with line activity between them; runaway Y means sync was lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_seen_hs <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_vs_edge) begin
                        r_state   <= ST_SYNC;
                        r_seen_hs <= 1'b0;
                    end
                end
                ST_SYNC: begin
                    if (w_vs_edge) begin
                        r_seen_hs <= 1'b0;
                        if (r_seen_hs) begin
                            r_state  <= ST_RUN;
                            r_locked <= 1'b1;
                        end
                    end else if (w_hs_edge) begin
                        r_seen_hs <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (r_y == 11'h7FF) begin
                        r_state  <= ST_IDLE;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign vif.wren         = r_wren;
    assign vif.wraddr       = r_wraddr;
    assign vif.wrdata       = r_wrdata;
    assign vif.starttrigger = r_trig;
    assign vif.locked       = r_locked;
endmodule
